// File: rtl/psum_accum_buffer_pkg.sv
// Shared constants, FSM encoding and lane arithmetic for the psum channel accumulator.
package psum_accum_buffer_pkg;

  localparam int PSUM_W     = 20;
  localparam int TIME_STEPS = 4;
  localparam int DEPTH      = 1024;
  localparam int ADDR_W     = 10;
  localparam int WORD_W     = PSUM_W * TIME_STEPS;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FIRST = 2'd1,
    S_ACC   = 2'd2,
    S_LAST  = 2'd3
  } state_e;

  localparam logic [PSUM_W-1:0] LANE_MAX = {1'b0, {(PSUM_W-1){1'b1}}};
  localparam logic [PSUM_W-1:0] LANE_MIN = {1'b1, {(PSUM_W-1){1'b0}}};

  // Lanes are sign-extended by one bit; disagreement of the top two sum bits means overflow.
  function automatic logic [WORD_W-1:0] sat_add_word(input logic [WORD_W-1:0] a,
                                                     input logic [WORD_W-1:0] b);
    logic [WORD_W-1:0] r;
    logic [PSUM_W:0]   s;
    r = '0;
    for (int t = 0; t < TIME_STEPS; t++) begin
      s = {a[PSUM_W*t+PSUM_W-1], a[PSUM_W*t +: PSUM_W]} +
          {b[PSUM_W*t+PSUM_W-1], b[PSUM_W*t +: PSUM_W]};
      if (s[PSUM_W] != s[PSUM_W-1]) begin
        r[PSUM_W*t +: PSUM_W] = s[PSUM_W] ? LANE_MIN : LANE_MAX;
      end else begin
        r[PSUM_W*t +: PSUM_W] = s[PSUM_W-1:0];
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/psum_accum_buffer_sdp_ram.sv
// Simple dual-port accumulation RAM with one-cycle registered read.
module psum_sdp_ram
  import psum_accum_buffer_pkg::*;
(
  input  logic              s_clk,
  input  logic              i_we,
  input  logic [ADDR_W-1:0] i_waddr,
  input  logic [WORD_W-1:0] i_wdata,
  input  logic [ADDR_W-1:0] i_raddr,
  output logic [WORD_W-1:0] o_rdata
);

  logic [WORD_W-1:0] r_mem [DEPTH];
  logic [WORD_W-1:0] r_rdata;

  // Write port
  always_ff @(posedge s_clk) begin
    if (i_we) begin
      r_mem[i_waddr] <= i_wdata;
    end
  end

  // Registered read port; same-edge writes are covered by forwarding in the parent
  always_ff @(posedge s_clk) begin
    r_rdata <= r_mem[i_raddr];
  end

  assign o_rdata = r_rdata;

endmodule

// File: rtl/psum_accum_buffer.sv
// Accumulates per-pixel partial sums over several input-channel passes and
// streams the final sums to the LIF stage on the last pass.
module psum_accum_buffer
  import psum_accum_buffer_pkg::*;
(
  input  logic              s_clk,
  input  logic              s_rst,
  input  logic              code_valid,
  input  logic [15:0]       conv_img_size,
  input  logic [15:0]       conv_in_passes,
  input  logic              i_psum_valid,
  input  logic [WORD_W-1:0] i_psum_data,
  output logic              read_1line_req,
  output logic [WORD_W-1:0] read_1line_data,
  output logic              o_channel_done,
  output logic [15:0]       o_pass_idx
);

  state_e            r_state;
  logic [15:0]       r_passes, r_img_size, r_pass_idx;
  logic              r_cfg_d;
  logic [31:0]       r_pix_total;
  logic [ADDR_W-1:0] r_pix_cnt;

  logic              r_s1_valid, r_s1_first, r_s1_last, r_s1_done;
  logic [ADDR_W-1:0] r_s1_addr;
  logic [WORD_W-1:0] r_s1_data;
  logic              r_s2_valid, r_s2_last, r_s2_done;
  logic [ADDR_W-1:0] r_s2_addr;
  logic [WORD_W-1:0] r_s2_sum;
  logic              r_s3_valid;
  logic [ADDR_W-1:0] r_s3_addr;
  logic [WORD_W-1:0] r_s3_data;
  logic              r_out_req, r_out_done;
  logic [WORD_W-1:0] r_out_data;

  logic              w_accept, w_single, w_is_first, w_is_last, w_pass_end, w_ram_we;
  logic [WORD_W-1:0] w_ram_rdata, w_s1_prev, w_s1_sum;

  // The config cycle and the one after it (pix_total not yet valid) drop input words.
  assign w_accept   = i_psum_valid && (r_state != S_IDLE) && !code_valid && !r_cfg_d;
  assign w_single   = (r_passes == 16'd1);
  assign w_is_first = (r_state == S_FIRST);
  assign w_is_last  = (r_state == S_LAST) || (w_is_first && w_single);
  assign w_pass_end = ({{(32-ADDR_W){1'b0}}, r_pix_cnt} == (r_pix_total - 32'd1));
  assign w_ram_we   = r_s2_valid && !r_s2_last && !code_valid;

  psum_sdp_ram u_ram (
    .s_clk   (s_clk),
    .i_we    (w_ram_we),
    .i_waddr (r_s2_addr),
    .i_wdata (r_s2_sum),
    .i_raddr (r_pix_cnt),
    .o_rdata (w_ram_rdata)
  );

  // Configuration latch, pixel/pass counters and pass FSM
  always_ff @(posedge s_clk or posedge s_rst) begin
    if (s_rst) begin
      r_state     <= S_IDLE;
      r_passes    <= 16'd0;
      r_img_size  <= 16'd0;
      r_cfg_d     <= 1'b0;
      r_pix_total <= 32'd0;
      r_pix_cnt   <= '0;
      r_pass_idx  <= 16'd0;
    end else if (code_valid) begin
      r_passes   <= (conv_in_passes == 16'd0) ? 16'd1 : conv_in_passes;
      r_img_size <= conv_img_size;
      r_cfg_d    <= 1'b1;
      r_state    <= S_FIRST;
      r_pix_cnt  <= '0;
      r_pass_idx <= 16'd0;
    end else begin
      r_cfg_d <= 1'b0;
      if (r_cfg_d) begin
        r_pix_total <= {16'd0, r_img_size} * {16'd0, r_img_size};
      end
      if (w_accept) begin
        if (w_pass_end) begin
          r_pix_cnt <= '0;
          case (r_state)
            S_FIRST: begin
              if (w_single) begin
                r_pass_idx <= 16'd0;
              end else begin
                r_pass_idx <= 16'd1;
                r_state    <= (r_passes == 16'd2) ? S_LAST : S_ACC;
              end
            end
            S_ACC: begin
              r_pass_idx <= r_pass_idx + 16'd1;
              if (r_pass_idx == (r_passes - 16'd2)) begin
                r_state <= S_LAST;
              end
            end
            S_LAST: begin
              r_pass_idx <= 16'd0;
              r_state    <= S_FIRST;
            end
            default: begin
              r_pass_idx <= 16'd0;
              r_state    <= S_IDLE;
            end
          endcase
        end else begin
          r_pix_cnt <= r_pix_cnt + ADDR_W'(1);
        end
      end
    end
  end

  // Stage 1: pick the freshest previous sum (stage-2 write, then the write retired last cycle, then RAM)
  always_comb begin
    w_s1_prev = w_ram_rdata;
    if (r_s2_valid && !r_s2_last && (r_s2_addr == r_s1_addr)) begin
      w_s1_prev = r_s2_sum;
    end else if (r_s3_valid && (r_s3_addr == r_s1_addr)) begin
      w_s1_prev = r_s3_data;
    end else begin
      w_s1_prev = w_ram_rdata;
    end
    if (r_s1_first) begin
      w_s1_sum = r_s1_data;
    end else begin
      w_s1_sum = sat_add_word(w_s1_prev, r_s1_data);
    end
  end

  // Pipeline registers and output register; a config strobe flushes everything in flight
  always_ff @(posedge s_clk or posedge s_rst) begin
    if (s_rst) begin
      r_s1_valid <= 1'b0;
      r_s1_first <= 1'b0;
      r_s1_last  <= 1'b0;
      r_s1_done  <= 1'b0;
      r_s1_addr  <= '0;
      r_s1_data  <= '0;
      r_s2_valid <= 1'b0;
      r_s2_last  <= 1'b0;
      r_s2_done  <= 1'b0;
      r_s2_addr  <= '0;
      r_s2_sum   <= '0;
      r_s3_valid <= 1'b0;
      r_s3_addr  <= '0;
      r_s3_data  <= '0;
      r_out_req  <= 1'b0;
      r_out_done <= 1'b0;
      r_out_data <= '0;
    end else if (code_valid) begin
      r_s1_valid <= 1'b0;
      r_s2_valid <= 1'b0;
      r_s3_valid <= 1'b0;
      r_out_req  <= 1'b0;
      r_out_done <= 1'b0;
    end else begin
      r_s1_valid <= w_accept;
      r_s1_first <= w_is_first;
      r_s1_last  <= w_is_last;
      r_s1_done  <= w_is_last && w_pass_end;
      r_s1_addr  <= r_pix_cnt;
      r_s1_data  <= i_psum_data;
      r_s2_valid <= r_s1_valid;
      r_s2_last  <= r_s1_last;
      r_s2_done  <= r_s1_done;
      r_s2_addr  <= r_s1_addr;
      r_s2_sum   <= w_s1_sum;
      r_s3_valid <= w_ram_we;
      r_s3_addr  <= r_s2_addr;
      r_s3_data  <= r_s2_sum;
      r_out_req  <= r_s2_valid && r_s2_last;
      r_out_done <= r_s2_valid && r_s2_last && r_s2_done;
      if (r_s2_valid && r_s2_last) begin
        r_out_data <= r_s2_sum;
      end
    end
  end

  assign read_1line_req  = r_out_req;
  assign read_1line_data = r_out_data;
  assign o_channel_done  = r_out_done;
  assign o_pass_idx      = r_pass_idx;

endmodule

// File: doc/psum_accum_buffer.md
Name: psum_accum_buffer

Overview:
- Channel-accumulation stage directly upstream of the psum LIF stage.
- Takes per-pixel partial-sum words from the PE array and accumulates them in an on-chip RAM across `conv_in_passes` input-channel passes.
- On the last pass, streams the final sums out as `read_1line_req` / `read_1line_data`, which the LIF stage consumes with no backpressure.
- Each word holds TIME_STEPS signed lanes. Lane t occupies bits [PSUM_W*(t+1)-1 : PSUM_W*t].

Parameters:
- PSUM_W, 20, signed lane width (matches ERS_MAX_WIDTH).
- TIME_STEPS, 4, lanes per word.
- DEPTH, 1024, maximum pixels per output channel.
- ADDR_W, 10, log2(DEPTH).

Ports:
- s_clk  in  1  clock.
- s_rst  in  1  asynchronous, active-high reset.
- code_valid  in  1  layer-config strobe.
- conv_img_size  in  16  feature-map side length; pixel count = side².
- conv_in_passes  in  16  number of accumulation passes per output channel.
- i_psum_valid  in  1  input word valid. No ready signal; upstream streams pixels in raster order.
- i_psum_data  in  PSUM_W*TIME_STEPS  partial-sum word.
- read_1line_req  out  1  final-sum word valid.
- read_1line_data  out  PSUM_W*TIME_STEPS  final-sum word.
- o_channel_done  out  1  one-cycle pulse with the last output word of a channel.
- o_pass_idx  out  16  current pass index (debug/status).

Behaviour:
- Reset values:
  - all outputs 0;
  - state S_IDLE;
  - counters 0;
  - latched config 0.
  - RAM contents are not cleared; the first pass overwrites them.
- Configuration:
  - On `code_valid`, latch `conv_in_passes` (0 is treated as 1) and `conv_img_size`.
  - Register pix_total = size*size one cycle later.
  - Enter S_FIRST and clear the pixel and pass counters.
  - `i_psum_valid` is ignored in the `code_valid` cycle and the following cycle.
  - pix_total > DEPTH is unsupported.
- FSM states: S_IDLE, S_FIRST (pass 0), S_ACC (passes 1..N-2), S_LAST (pass N-1).
  - With N=1, S_FIRST also acts as last.
  - A pass ends when the pixel counter reaches pix_total-1 on a valid input. The counter then wraps to 0 and the pass index increments.
  - S_FIRST → S_ACC if N>2, → S_LAST if N=2, → S_FIRST (next channel) if N=1.
  - S_ACC → S_LAST after pass N-2.
  - S_LAST → S_FIRST at end of pass, with the pass index reset to 0.
- Three-stage pipeline:
  - Stage 0: input registered; RAM read at pixel address.
  - Stage 1: RAM data available (1-cycle read latency); per-lane add.
  - Stage 2: RAM write, or output register.
- Per pass type:
  - Pass 0: sum = input (RAM read data ignored).
  - Middle passes: sum = RAM + input.
  - Last pass: sum = RAM + input, driven out and not written back.
  - N=1: input passes straight through.
- Arithmetic:
  - Per lane, signed PSUM_W + PSUM_W, saturated to [-2^(PSUM_W-1), 2^(PSUM_W-1)-1].
  - No cross-lane carry.
- Hazard forwarding:
  - If a stage-1 read address equals the stage-2 write address, or the write in flight one cycle earlier, use the forwarded write data instead of RAM data.
  - Forwarding is required for pix_total ≤ 2 (e.g. size 1).
- Latency and output timing:
  - `read_1line_req` asserts exactly 3 cycles after the matching `i_psum_valid`.
  - Throughput is one word per cycle; gaps in the input are preserved in the output.
- `o_channel_done` asserts in the same cycle as the `read_1line_req` of pixel pix_total-1 on the last pass.
- `code_valid` mid-operation:
  - In-flight pipeline stages are flushed: no write, no output.
  - Counters are cleared and the state goes to S_FIRST.
- `i_psum_valid` in S_IDLE is ignored.

Decomposition:
- Shared package holds: PSUM_W, TIME_STEPS, DEPTH, ADDR_W, FSM state encodings, and a per-lane saturating-add function.
- One sub-module, `psum_sdp_ram`:
  - simple dual-port RAM, DEPTH × PSUM_W*TIME_STEPS;
  - 1-cycle registered read;
  - write-first behaviour not relied upon.

Test Plan:
- Single pass: N=1, size=2, words with lanes {1,2,3,4}×pixel index.
  - Expect 4 output words, identical to input, 3 cycles later.
  - `o_channel_done` on the 4th word.
- Three-pass accumulate: N=3, size=4.
  - Pass inputs: all lanes 5, then -2, then 10.
  - Expect 16 outputs with all lanes 13, only during pass 2.
  - No outputs during passes 0–1.
- Saturation: PSUM_W=20, N=2, lane inputs 524287 then 1.
  - Expect 524287.
  - Inputs -524288 and -1 → expect -524288.
- Forwarding: size=1, N=4, back-to-back inputs 1, 2, 3, 4 on consecutive cycles.
  - Expect a single output of 10.
- Abort and back-to-back channels: `code_valid` mid pass 1 (N=2, size=3), then 2 full channels with inputs 7 and 1.
  - Expect no output before the abort.
  - Each channel then emits 9 words of 8.
  - Two `o_channel_done` pulses.
- Async reset mid pass:
  - Outputs go to 0 immediately; state S_IDLE.
  - After `code_valid`, a fresh channel is correct.
